hack_ram_bist: RTL

- March C- built-in self-test initiator for the Hack RAM family; drives a RAM64's load/in/address and checks its out.
- Sits between the RAM under test and a system-level test controller. Replaces hand-written read/write stimulus with a hardware sequencer.
- Reports pass/fail, plus the first failing address and the data read there.

---
 rtl/hack_bist_pkg.sv | 30 +++
 rtl/hack_bist_addr_ctr.sv | 33 +++
 rtl/hack_ram_bist.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hack_bist_pkg.sv
// Shared types and the March C- element table for the Hack RAM BIST.
package hack_bist_pkg;

    localparam int HACK_ADDR_W = 6;
    localparam int HACK_DATA_W = 16;
    localparam int HACK_DEPTH  = 2 ** HACK_ADDR_W;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
    typedef enum logic       {PH_R, PH_W}             phase_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} bist_state_e;

    // rd_one/wr_one select ~PAT0 instead of PAT0 for that op
    typedef struct packed {
        logic down;
        logic has_r;
        logic rd_one;
        logic has_w;
        logic wr_one;
    } elem_cfg_t;

    localparam elem_cfg_t ELEM_TAB [6] = '{
        '{down: 1'b0, has_r: 1'b0, rd_one: 1'b0, has_w: 1'b1, wr_one: 1'b0},
        '{down: 1'b0, has_r: 1'b1, rd_one: 1'b0, has_w: 1'b1, wr_one: 1'b1},
        '{down: 1'b0, has_r: 1'b1, rd_one: 1'b1, has_w: 1'b1, wr_one: 1'b0},
        '{down: 1'b1, has_r: 1'b1, rd_one: 1'b0, has_w: 1'b1, wr_one: 1'b1},
        '{down: 1'b1, has_r: 1'b1, rd_one: 1'b1, has_w: 1'b1, wr_one: 1'b0},
        '{down: 1'b0, has_r: 1'b1, rd_one: 1'b0, has_w: 1'b0, wr_one: 1'b0}
    };

endpackage

// File: rtl/hack_bist_addr_ctr.sv
// Up/down March address counter: load picks start address and direction,
// enable steps one word, term flags the last address of the element.
module hack_bist_addr_ctr #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_i,
    input  logic              dir_down_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              term_o
);

    logic [ADDR_W-1:0] addr_q;
    logic              down_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else if (ld_i) begin
            addr_q <= dir_down_i ? '1 : '0;
            down_q <= dir_down_i;
        end else if (en_i) begin
            addr_q <= down_q ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    assign addr_o = addr_q;
    assign term_o = down_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/hack_ram_bist.sv
// March C- BIST sequencer for a Hack RAM64. Optional HACK_RAM_BIST_ERR_COUNT_EN
// runs the full march regardless of mismatches and exposes err_count.
module hack_ram_bist
    import hack_bist_pkg::*;
#(
    parameter int                 ADDR_W = HACK_ADDR_W,
    parameter int                 DATA_W = HACK_DATA_W,
    parameter logic [DATA_W-1:0]  PAT0   = 16'h5555
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              ram_load,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
`ifdef HACK_RAM_BIST_ERR_COUNT_EN
   ,output logic [ADDR_W+2:0] err_count
`endif
);

`ifdef HACK_RAM_BIST_ERR_COUNT_EN
    localparam bit STOP_ON_FAIL = 1'b0;
    logic [ADDR_W+2:0] err_cnt_q;
    assign err_count = err_cnt_q;
`else
    localparam bit STOP_ON_FAIL = 1'b1;
`endif

    bist_state_e       state_q;
    march_elem_e       elem_q;
    phase_e            phase_q;
    logic              busy_q, done_q, pass_q, err_seen_q, ram_load_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q, ram_in_q;

    logic              ctr_ld, ctr_en, ctr_term;
    logic [ADDR_W-1:0] ctr_addr;

    function automatic logic [DATA_W-1:0] pat(input logic one);
        return one ? ~PAT0 : PAT0;
    endfunction

    logic        start_run, mism, stop, op_last, step_done, elem_end, last;
    march_elem_e elem_nx;
    logic        nx_has_r;
    logic [DATA_W-1:0] nx_pat;

    assign start_run = start && (state_q != ST_RUN);
    assign mism      = (state_q == ST_RUN) && (phase_q == PH_R) &&
                       (ram_out != pat(ELEM_TAB[elem_q].rd_one));
    assign stop      = mism && STOP_ON_FAIL;
    assign op_last   = (phase_q == PH_W) || !ELEM_TAB[elem_q].has_w;
    assign step_done = (state_q == ST_RUN) && op_last && !stop;
    assign elem_end  = step_done && ctr_term;
    assign last      = elem_end && (elem_q == M5);

    // Element whose first op is issued next; stays put inside an element
    assign elem_nx   = start_run                  ? M0 :
                       (elem_end && elem_q != M5) ? march_elem_e'(elem_q + 3'd1) :
                                                    elem_q;
    assign nx_has_r  = ELEM_TAB[elem_nx].has_r;
    assign nx_pat    = nx_has_r ? pat(ELEM_TAB[elem_nx].rd_one)
                                : pat(ELEM_TAB[elem_nx].wr_one);

    assign ctr_ld = start_run || (elem_end && !last);
    assign ctr_en = step_done && !ctr_term;

    hack_bist_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_i       (ctr_ld),
        .dir_down_i (ELEM_TAB[elem_nx].down),
        .en_i       (ctr_en),
        .addr_o     (ctr_addr),
        .term_o     (ctr_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= M0;
            phase_q     <= PH_R;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_seen_q  <= 1'b0;
            ram_load_q  <= 1'b0;
            ram_in_q    <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
`ifdef HACK_RAM_BIST_ERR_COUNT_EN
            err_cnt_q   <= '0;
`endif
        end else if (start_run) begin
            state_q     <= ST_RUN;
            elem_q      <= elem_nx;
            phase_q     <= nx_has_r ? PH_R : PH_W;
            ram_load_q  <= !nx_has_r;
            ram_in_q    <= nx_pat;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_seen_q  <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
`ifdef HACK_RAM_BIST_ERR_COUNT_EN
            err_cnt_q   <= '0;
`endif
        end else if (state_q == ST_RUN) begin
            if (mism) begin
                err_seen_q <= 1'b1;
                if (!err_seen_q) begin
                    fail_addr_q <= ctr_addr;
                    fail_data_q <= ram_out;
                end
`ifdef HACK_RAM_BIST_ERR_COUNT_EN
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
`endif
            end
            if (stop) begin
                state_q    <= ST_DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                pass_q     <= 1'b0;
                ram_load_q <= 1'b0;
            end else if (phase_q == PH_R && ELEM_TAB[elem_q].has_w) begin
                phase_q    <= PH_W;
                ram_load_q <= 1'b1;
                ram_in_q   <= pat(ELEM_TAB[elem_q].wr_one);
            end else if (last) begin
                state_q    <= ST_DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                pass_q     <= !(err_seen_q || mism);
                ram_load_q <= 1'b0;
            end else begin
                elem_q     <= elem_nx;
                phase_q    <= nx_has_r ? PH_R : PH_W;
                ram_load_q <= !nx_has_r;
                ram_in_q   <= nx_pat;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign ram_load    = ram_load_q;
    assign ram_in      = ram_in_q;
    assign ram_address = ctr_addr;

endmodule
